umi_req_arbiter: RTL and testbench

- Shares one UMI device (e.g. umiram) between N UMI hosts.
- Request path: round-robin arbitration, then one registered output stage to the device.
- Response path: an in-order tag FIFO records the host of each issued request, and each device response is routed back to that host.
- Sits between host-side umi_rx_sim/umi_tx_sim pairs (or RTL hosts) and the shared device.

---
 rtl/umi_req_arbiter.sv | 109 ++++++++++
 tb/tb_umi_req_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_req_arbiter.sv
// umi_req_arbiter: round-robin sharing of one UMI device between N hosts with in-order response routing
module umi_req_arbiter #(
  parameter int N     = 2,
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic [N-1:0]    host_req_valid,
  output logic [N-1:0]    host_req_ready,
  input  logic [N*CW-1:0] host_req_cmd,
  input  logic [N*AW-1:0] host_req_dstaddr,
  input  logic [N*AW-1:0] host_req_srcaddr,
  input  logic [N*DW-1:0] host_req_data,
  output logic [N-1:0]    host_resp_valid,
  input  logic [N-1:0]    host_resp_ready,
  output logic [CW-1:0]   host_resp_cmd,
  output logic [AW-1:0]   host_resp_dstaddr,
  output logic [AW-1:0]   host_resp_srcaddr,
  output logic [DW-1:0]   host_resp_data,
  output logic            udev_req_valid,
  input  logic            udev_req_ready,
  output logic [CW-1:0]   udev_req_cmd,
  output logic [AW-1:0]   udev_req_dstaddr,
  output logic [AW-1:0]   udev_req_srcaddr,
  output logic [DW-1:0]   udev_req_data,
  input  logic            udev_resp_valid,
  output logic            udev_resp_ready,
  input  logic [CW-1:0]   udev_resp_cmd,
  input  logic [AW-1:0]   udev_resp_dstaddr,
  input  logic [AW-1:0]   udev_resp_srcaddr,
  input  logic [DW-1:0]   udev_resp_data,
  output logic            err_unexpected_resp
);
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  logic [CW-1:0] cmd_a [N];
  logic [AW-1:0] dst_a [N];
  logic [AW-1:0] src_a [N];
  logic [DW-1:0] data_a [N];
  logic [IW-1:0] rr, g, idx, h;
  logic [IW-1:0] tags [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [PW:0]   count;
  logic          accept, nonempty, pop;
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign cmd_a[i]  = host_req_cmd[i*CW +: CW];
    assign dst_a[i]  = host_req_dstaddr[i*AW +: AW];
    assign src_a[i]  = host_req_srcaddr[i*AW +: AW];
    assign data_a[i] = host_req_data[i*DW +: DW];
  end
  // first valid host at or after rr, wrapping; the smallest offset is written last and wins
  always_comb begin
    g = '0;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((32'(rr) + k) % N);
      g = host_req_valid[idx] ? idx : g;
    end
  end
  // ready uses the registered count, so a same-cycle pop cannot open a full FIFO
  assign accept = nreset & (|host_req_valid) & (~udev_req_valid | udev_req_ready) & (count < (PW+1)'(DEPTH));
  assign host_req_ready = accept ? {{(N-1){1'b0}}, 1'b1} << g : '0;
  assign h = tags[rptr];
  assign nonempty = count != '0;
  assign host_resp_valid = nonempty ? {{(N-1){1'b0}}, udev_resp_valid} << h : '0;
  assign udev_resp_ready = nreset & (~nonempty | host_resp_ready[h]);
  assign pop = nonempty & udev_resp_valid & udev_resp_ready;
  assign host_resp_cmd = udev_resp_cmd;
  assign host_resp_dstaddr = udev_resp_dstaddr;
  assign host_resp_srcaddr = udev_resp_srcaddr;
  assign host_resp_data = udev_resp_data;
  // output register, rr pointer, tag FIFO bookkeeping and sticky error
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      udev_req_valid <= 1'b0;
      udev_req_cmd <= '0;
      udev_req_dstaddr <= '0;
      udev_req_srcaddr <= '0;
      udev_req_data <= '0;
      rr <= '0;
      wptr <= '0;
      rptr <= '0;
      count <= '0;
      err_unexpected_resp <= 1'b0;
    end else begin
      if (accept) begin
        udev_req_valid <= 1'b1;
        udev_req_cmd <= cmd_a[g];
        udev_req_dstaddr <= dst_a[g];
        udev_req_srcaddr <= src_a[g];
        udev_req_data <= data_a[g];
        rr <= (g == IW'(N - 1)) ? '0 : g + 1'b1;
      end else if (udev_req_ready) begin
        udev_req_valid <= 1'b0;
      end
      wptr <= wptr + PW'(accept);
      rptr <= rptr + PW'(pop);
      count <= count + (PW+1)'(accept) - (PW+1)'(pop);
      if (udev_resp_valid && !nonempty) err_unexpected_resp <= 1'b1;
    end
  end
  // tag storage needs no reset: entries are only read while count is nonzero
  always_ff @(posedge clk) begin
    if (accept) tags[wptr] <= g;
  end
endmodule

// File: tb/tb_umi_req_arbiter.sv
// tb_umi_req_arbiter: randomized check of umi_req_arbiter against a queue-based behavioural model
module tb_umi_req_arbiter;
  localparam int N = 3, DW = 32, AW = 16, CW = 8, DEPTH = 4;
  typedef struct {
    int host;
    logic [CW-1:0] cmd;
    logic [AW-1:0] dst;
    logic [AW-1:0] src;
    logic [DW-1:0] data;
  } req_t;
  logic clk = 1'b0;
  logic nreset = 1'b1;
  logic [N-1:0] host_req_valid, host_req_ready, host_resp_valid, host_resp_ready;
  logic [N*CW-1:0] host_req_cmd;
  logic [N*AW-1:0] host_req_dstaddr, host_req_srcaddr;
  logic [N*DW-1:0] host_req_data;
  logic [CW-1:0] host_resp_cmd, udev_req_cmd, udev_resp_cmd;
  logic [AW-1:0] host_resp_dstaddr, host_resp_srcaddr, udev_req_dstaddr, udev_req_srcaddr;
  logic [AW-1:0] udev_resp_dstaddr, udev_resp_srcaddr;
  logic [DW-1:0] host_resp_data, udev_req_data, udev_resp_data;
  logic udev_req_valid, udev_req_ready, udev_resp_valid, udev_resp_ready, err_unexpected_resp;
  logic [CW-1:0] hc [N];
  logic [AW-1:0] hdst [N];
  logic [AW-1:0] hsrc [N];
  logic [DW-1:0] hd [N];
  for (genvar i = 0; i < N; i++) begin : g_pack
    assign host_req_cmd[i*CW +: CW] = hc[i];
    assign host_req_dstaddr[i*AW +: AW] = hdst[i];
    assign host_req_srcaddr[i*AW +: AW] = hsrc[i];
    assign host_req_data[i*DW +: DW] = hd[i];
  end
  always #5 clk = ~clk;
  umi_req_arbiter #(.N(N), .DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .nreset(nreset),
    .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
    .host_req_cmd(host_req_cmd), .host_req_dstaddr(host_req_dstaddr),
    .host_req_srcaddr(host_req_srcaddr), .host_req_data(host_req_data),
    .host_resp_valid(host_resp_valid), .host_resp_ready(host_resp_ready),
    .host_resp_cmd(host_resp_cmd), .host_resp_dstaddr(host_resp_dstaddr),
    .host_resp_srcaddr(host_resp_srcaddr), .host_resp_data(host_resp_data),
    .udev_req_valid(udev_req_valid), .udev_req_ready(udev_req_ready),
    .udev_req_cmd(udev_req_cmd), .udev_req_dstaddr(udev_req_dstaddr),
    .udev_req_srcaddr(udev_req_srcaddr), .udev_req_data(udev_req_data),
    .udev_resp_valid(udev_resp_valid), .udev_resp_ready(udev_resp_ready),
    .udev_resp_cmd(udev_resp_cmd), .udev_resp_dstaddr(udev_resp_dstaddr),
    .udev_resp_srcaddr(udev_resp_srcaddr), .udev_resp_data(udev_resp_data),
    .err_unexpected_resp(err_unexpected_resp)
  );
  int checks = 0, failures = 0;
  int m_rr;
  int m_tags[$];
  bit m_vld, m_err;
  req_t m_req;
  req_t dq[$];
  req_t sb[$];
  bit e_acc, e_pop, e_err, r_reqhs, r_resphs, dev_auto;
  int e_g;
  req_t r_req;
  logic [N-1:0] s_hrr, s_hrv;
  logic s_urr, s_uv, s_err;
  logic [AW-1:0] s_dst;
  logic [N-1:0] lit_hrr [5] = '{3'b001, 3'b010, 3'b001, 3'b010, 3'b000};
  logic [AW-1:0] lit_dst [5] = '{16'h0, 16'h0, 16'h100, 16'h0, 16'h100};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic req_t host_req(int i);
    req_t r;
    r.host = i;
    r.cmd = hc[i];
    r.dst = hdst[i];
    r.src = hsrc[i];
    r.data = hd[i];
    return r;
  endfunction

  function automatic req_t resp_of(req_t q);
    req_t r = q;
    r.dst = q.src;
    r.src = q.dst;
    r.data = ~q.data;
    return r;
  endfunction

  task automatic compare();
    logic [N-1:0] ehrr, ehrv;
    logic eurr;
    int h;
    s_hrr = host_req_ready;
    s_hrv = host_resp_valid;
    s_urr = udev_resp_ready;
    s_uv = udev_req_valid;
    s_err = err_unexpected_resp;
    s_dst = udev_req_dstaddr;
    e_acc = 0;
    e_pop = 0;
    e_err = 0;
    e_g = -1;
    r_reqhs = 0;
    r_resphs = 0;
    if (!nreset) begin
      chk("rst_req_ready", host_req_ready, 0);
      chk("rst_resp_valid", host_resp_valid, 0);
      chk("rst_udev_resp_ready", udev_resp_ready, 0);
      chk("rst_udev_req_valid", udev_req_valid, 0);
      chk("rst_udev_req_fields", {udev_req_cmd, udev_req_dstaddr, udev_req_srcaddr}, 0);
      chk("rst_udev_req_data", udev_req_data, 0);
      chk("rst_err", err_unexpected_resp, 0);
      return;
    end
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (e_g < 0 && host_req_valid[i]) e_g = i;
    end
    e_acc = e_g >= 0 && (!m_vld || udev_req_ready) && m_tags.size() < DEPTH;
    ehrr = e_acc ? N'(1) << e_g : '0;
    if (m_tags.size() > 0) begin
      h = m_tags[0];
      ehrv = udev_resp_valid ? N'(1) << h : '0;
      eurr = host_resp_ready[h];
      e_pop = udev_resp_valid && eurr;
    end else begin
      ehrv = '0;
      eurr = 1'b1;
      e_err = udev_resp_valid;
    end
    chk("host_req_ready", host_req_ready, ehrr);
    chk("udev_req_valid", udev_req_valid, m_vld);
    if (m_vld) begin
      chk("udev_req_cmd", udev_req_cmd, m_req.cmd);
      chk("udev_req_dstaddr", udev_req_dstaddr, m_req.dst);
      chk("udev_req_srcaddr", udev_req_srcaddr, m_req.src);
      chk("udev_req_data", udev_req_data, m_req.data);
    end
    chk("host_resp_valid", host_resp_valid, ehrv);
    chk("udev_resp_ready", udev_resp_ready, eurr);
    chk("err_unexpected_resp", err_unexpected_resp, m_err);
    for (int i = 0; i < N; i++) begin
      if (host_resp_valid[i] && host_resp_ready[i]) begin
        if (sb.size() == 0) chk("resp_without_request", host_resp_valid, 0);
        else begin
          chk("resp_host", i, sb[0].host);
          chk("resp_cmd", host_resp_cmd, sb[0].cmd);
          chk("resp_addr", {host_resp_dstaddr, host_resp_srcaddr}, {sb[0].dst, sb[0].src});
          chk("resp_data", host_resp_data, sb[0].data);
          void'(sb.pop_front());
        end
      end
    end
    r_reqhs = udev_req_valid && udev_req_ready;
    r_req.host = 0;
    r_req.cmd = udev_req_cmd;
    r_req.dst = udev_req_dstaddr;
    r_req.src = udev_req_srcaddr;
    r_req.data = udev_req_data;
    r_resphs = udev_resp_valid && udev_resp_ready;
  endtask

  task automatic update();
    if (!nreset) begin
      m_rr = 0;
      m_tags.delete();
      m_vld = 0;
      m_err = 0;
      dq.delete();
      sb.delete();
      udev_resp_valid = 0;
      return;
    end
    if (e_pop) void'(m_tags.pop_front());
    if (e_err) m_err = 1;
    if (e_acc) begin
      m_req = host_req(e_g);
      m_vld = 1;
      m_tags.push_back(e_g);
      m_rr = (e_g + 1) % N;
      sb.push_back(resp_of(m_req));
    end else if (udev_req_ready) m_vld = 0;
    if (r_reqhs) dq.push_back(resp_of(r_req));
    if (r_resphs && dq.size() > 0) begin
      void'(dq.pop_front());
      udev_resp_valid = 0;
    end
    if (dev_auto && !udev_resp_valid && dq.size() > 0 && $urandom_range(0, 2) != 0) udev_resp_valid = 1;
    if (dq.size() > 0) begin
      udev_resp_cmd = dq[0].cmd;
      udev_resp_dstaddr = dq[0].dst;
      udev_resp_srcaddr = dq[0].src;
      udev_resp_data = dq[0].data;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare();
    @(posedge clk);
    #1;
    update();
  endtask

  task automatic rand_hosts();
    host_req_valid = N'($urandom);
    for (int i = 0; i < N; i++) begin
      hc[i] = CW'($urandom);
      hdst[i] = AW'($urandom);
      hsrc[i] = AW'($urandom);
      hd[i] = DW'($urandom);
    end
  endtask

  initial begin
    rand_hosts();
    host_req_valid = '0;
    host_resp_ready = '1;
    udev_req_ready = 1'b1;
    udev_resp_valid = 1'b0;
    udev_resp_cmd = '0;
    udev_resp_dstaddr = '0;
    udev_resp_srcaddr = '0;
    udev_resp_data = '0;
    dev_auto = 0;
    nreset = 1'b0;
    repeat (2) tick();
    nreset = 1'b1;
    hdst[0] = 16'h0;
    hdst[1] = 16'h100;
    host_req_valid = 3'b011;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("lit_grant", s_hrr, lit_hrr[c]);
      chk("lit_issue_valid", s_uv, c > 0);
      if (c > 0) chk("lit_issue_dst", s_dst, lit_dst[c]);
    end
    udev_resp_valid = 1'b1;
    host_resp_ready = '0;
    repeat (3) begin
      tick();
      chk("lit_hold_resp_valid", s_hrv, 3'b001);
      chk("lit_hold_resp_ready", s_urr, 0);
      chk("lit_full_stall", s_hrr, 0);
    end
    host_resp_ready = '1;
    tick();
    chk("lit_release_resp_valid", s_hrv, 3'b001);
    chk("lit_release_resp_ready", s_urr, 1);
    chk("lit_pop_no_accept", s_hrr, 0);
    tick();
    chk("lit_accept_after_pop", s_hrr, 3'b001);
    host_req_valid = '0;
    dev_auto = 1;
    for (int c = 0; c < 100 && m_tags.size() > 0; c++) tick();
    chk("drain_done", m_tags.size(), 0);
    dev_auto = 0;
    tick();
    udev_resp_valid = 1'b1;
    udev_resp_data = DW'($urandom);
    tick();
    chk("lit_unexp_ready", s_urr, 1);
    chk("lit_unexp_no_valid", s_hrv, 0);
    chk("lit_err_before", s_err, 0);
    udev_resp_valid = 1'b0;
    tick();
    chk("lit_err_set", s_err, 1);
    tick();
    chk("lit_err_sticky", s_err, 1);
    host_req_valid = 3'b001;
    tick();
    nreset = 1'b0;
    tick();
    chk("lit_rst_err", s_err, 0);
    chk("lit_rst_issue", s_uv, 0);
    chk("lit_rst_ready", s_hrr, 0);
    nreset = 1'b1;
    dev_auto = 1;
    for (int c = 0; c < 4000; c++) begin
      rand_hosts();
      udev_req_ready = (c % 200 < 12) ? 1'b0 : ($urandom_range(0, 3) != 0);
      host_resp_ready = ($urandom_range(0, 3) != 0) ? '1 : N'($urandom);
      nreset = (c == 2000) ? 1'b0 : 1'b1;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
